// File: rtl/comp_seq.sv
// Sequential 16-bit unsigned magnitude comparator: one shared 4-bit slice, MSB-first, with valid/ready handshakes.
// Optional macro COMP_EARLY_EXIT_EN stops at the first differing slice; otherwise all four slices are always examined.
module comp_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        gt,
  output logic        eq,
  output logic        lt,
  output logic [2:0]  slices
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t      state, state_next;
  logic [15:0] a_reg, b_reg;
  logic [1:0]  idx;
  logic [2:0]  cnt;
  logic        decided;
  logic        a_greater;
  logic [3:0]  nib_a, nib_b;
  logic        nib_diff;
  logic        last_slice;

  function automatic logic [3:0] nibble(input logic [15:0] v, input logic [1:0] i);
    return v[{i, 2'b00} +: 4];
  endfunction

  always_comb begin
    nib_a    = nibble(a_reg, idx);
    nib_b    = nibble(b_reg, idx);
    nib_diff = (nib_a != nib_b);
`ifdef COMP_EARLY_EXIT_EN
    last_slice = nib_diff || (idx == 2'd0);
`else
    last_slice = (idx == 2'd0);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Result outputs are gated by HOLD so they read zero whenever out_valid is low.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    gt         = 1'b0;
    eq         = 1'b0;
    lt         = 1'b0;
    slices     = 3'd0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        if (last_slice) state_next = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        gt        = decided && a_greater;
        lt        = decided && !a_greater;
        eq        = !decided;
        slices    = cnt;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Only the most significant differing slice decides; later slices never overwrite it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= 16'd0;
      b_reg     <= 16'd0;
      idx       <= 2'd0;
      cnt       <= 3'd0;
      decided   <= 1'b0;
      a_greater <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      a_reg     <= a;
      b_reg     <= b;
      idx       <= 2'd3;
      cnt       <= 3'd0;
      decided   <= 1'b0;
      a_greater <= 1'b0;
    end else if (state == RUN) begin
      cnt <= cnt + 3'd1;
      idx <= idx - 2'd1;
      if (!decided && nib_diff) begin
        decided   <= 1'b1;
        a_greater <= (nib_a > nib_b);
      end
    end
  end

endmodule

// File: tb/tb_comp_seq.sv
// Directed self-checking bench for comp_seq; expected slice counts follow COMP_EARLY_EXIT_EN.
module tb_comp_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic        gt, eq, lt;
  logic [2:0]  slices;

  int n_cmp = 0;
  int n_err = 0;

  comp_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .gt        (gt),
    .eq        (eq),
    .lt        (lt),
    .slices    (slices)
  );

  always #5 clk = ~clk;

`ifdef COMP_EARLY_EXIT_EN
  localparam int EARLY = 1;
`else
  localparam int EARLY = 0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_in_ready"},  {31'd0, in_ready},  32'd1);
    check({tag, "_flags"},     {29'd0, gt, eq, lt}, 32'd0);
    check({tag, "_slices"},    {29'd0, slices},     32'd0);
  endtask

  task automatic check_result(input string tag, input int eg, input int ee, input int el, input int es);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_in_ready"},  {31'd0, in_ready},  32'd0);
    check({tag, "_gt"},        {31'd0, gt},        eg);
    check({tag, "_eq"},        {31'd0, eq},        ee);
    check({tag, "_lt"},        {31'd0, lt},        el);
    check({tag, "_slices"},    {29'd0, slices},    es);
  endtask

  // Called just after a rising edge with the DUT in IDLE.
  task automatic do_op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                       input int eg, input int ee, input int el, input int es,
                       input int hold_cycles, input bit mess, input bit early_ready);
    int lat;
    a = va;
    b = vb;
    in_valid = 1'b1;
    check({tag, "_accept_ready"}, {31'd0, in_ready}, 32'd1);
    tick();
    in_valid  = 1'b0;
    out_ready = early_ready;
    lat = 0;
    while (!out_valid && lat < 12) begin
      if (mess) begin
        check({tag, "_run_in_ready"}, {31'd0, in_ready}, 32'd0);
        a = 16'($urandom);
        b = 16'($urandom);
        in_valid = 1'b1;
      end
      tick();
      lat++;
    end
    in_valid = 1'b0;
    check({tag, "_latency"}, lat, es);
    check_result(tag, eg, ee, el, es);
    if (!early_ready) begin
      for (int i = 0; i < hold_cycles; i++) begin
        tick();
        check_result({tag, "_hold"}, eg, ee, el, es);
      end
      out_ready = 1'b1;
    end
    tick();
    out_ready = 1'b0;
    check_idle({tag, "_done"});
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = 16'd0;
    b         = 16'd0;
    #1;
    check_idle("reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check_idle("post_reset");

    do_op("eq_1234", 16'h1234, 16'h1234, 0, 1, 0, 4, 0, 1'b0, 1'b0);
    do_op("gt_8000", 16'h8000, 16'h7FFF, 1, 0, 0, EARLY ? 1 : 4, 0, 1'b0, 1'b0);
    do_op("lt_12f4", 16'h12F4, 16'h1305, 0, 0, 1, EARLY ? 2 : 4, 0, 1'b0, 1'b0);
    do_op("lt_hold", 16'h0000, 16'h0001, 0, 0, 1, 4, 3, 1'b0, 1'b0);
    do_op("iso_ffff", 16'hFFFF, 16'h0000, 1, 0, 0, EARLY ? 1 : 4, 0, 1'b1, 1'b1);

    // Abort an operation mid-RUN with an asynchronous reset pulse.
    a = 16'h00F0;
    b = 16'h00F1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("abort_in_run", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    check_idle("abort_asserted");
    tick();
    check_idle("abort_held");
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_idle("abort_quiet");
    end
    do_op("after_abort", 16'h00F0, 16'h00F1, 0, 0, 1, 4, 1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
